// File: rtl/subleq_seq.sv
// Subleq instruction sequencer: steps each (A, B, C) instruction through fetch,
// operand read, subtract/write-back and branch, one memory access per cycle.
module subleq_seq #(
  parameter int P_DATA = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [P_DATA-1:0] mem_rdata,
  output logic              addr_sel,
  output logic [P_DATA-1:0] pc_o,
  output logic [P_DATA-1:0] opr_o,
  output logic              mem_we,
  output logic [P_DATA-1:0] mem_wdata,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB, S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [P_DATA-1:0] r_pc;
  logic [P_DATA-1:0] r_ra;
  logic [P_DATA-1:0] r_rb;
  logic [P_DATA-1:0] r_rc;
  logic [P_DATA-1:0] r_va;

  logic [P_DATA-1:0] w_diff;
  logic              w_taken;
  logic              w_halt;

  // In WB the read data is mem[B]; the branch test looks at the wrapped difference.
  assign w_diff  = mem_rdata - r_va;
  assign w_taken = w_diff[P_DATA-1] | (w_diff == '0);
  assign w_halt  = w_taken & (&r_rc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FA;
      S_FA:    w_state_next = S_FB;
      S_FB:    w_state_next = S_FC;
      S_FC:    w_state_next = S_RA;
      S_RA:    w_state_next = S_RB;
      S_RB:    w_state_next = S_WB;
      S_WB:    w_state_next = w_halt ? S_HALT : S_FA;
      S_HALT:  if (start) w_state_next = S_FA;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
      r_va <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: if (start) r_pc <= '0;
        S_FB: r_ra <= mem_rdata;
        S_FC: r_rb <= mem_rdata;
        S_RA: r_rc <= mem_rdata;
        S_RB: r_va <= mem_rdata;
        S_WB: begin
          // A halting branch leaves pc pointing at the halting instruction.
          if (!w_taken) begin
            r_pc <= r_pc + P_DATA'(3);
          end else if (!w_halt) begin
            r_pc <= r_rc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_sel  = 1'b0;
    pc_o      = r_pc;
    opr_o     = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    halted    = 1'b0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_FA:   pc_o = r_pc;
      S_FB:   pc_o = r_pc + P_DATA'(1);
      S_FC:   pc_o = r_pc + P_DATA'(2);
      S_RA: begin
        addr_sel = 1'b1;
        opr_o    = r_ra;
      end
      S_RB: begin
        addr_sel = 1'b1;
        opr_o    = r_rb;
      end
      S_WB: begin
        addr_sel  = 1'b1;
        opr_o     = r_rb;
        mem_we    = 1'b1;
        mem_wdata = w_diff;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_subleq_seq.sv
// Directed bench for subleq_seq: a read-only synchronous memory model feeds the
// sequencer, and every cycle's address, strobe and write data are checked.
module tb_subleq_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mem_rdata;
  logic       addr_sel;
  logic [7:0] pc_o;
  logic [7:0] opr_o;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       halted;

  logic [7:0] mem [0:255];
  logic [7:0] mem_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  subleq_seq #(.P_DATA(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_rdata (mem_rdata),
    .addr_sel  (addr_sel),
    .pc_o      (pc_o),
    .opr_o     (opr_o),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_addr = addr_sel ? opr_o : pc_o;

  // Writes are checked on the ports; the array is only ever loaded by the stimulus.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".addr_sel"},  32'(addr_sel),  32'd0);
    check({tag, ".pc_o"},      32'(pc_o),      32'd0);
    check({tag, ".opr_o"},     32'(opr_o),     32'd0);
    check({tag, ".mem_we"},    32'(mem_we),    32'd0);
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".halted"},    32'(halted),    32'd0);
  endtask

  // Checks one busy cycle and advances to the next.
  task automatic cyc(input string tag, input logic sel, input logic [7:0] addr,
                     input logic we, input logic [7:0] wd);
    check({tag, ".addr_sel"}, 32'(addr_sel), 32'(sel));
    if (sel) begin
      check({tag, ".opr_o"}, 32'(opr_o), 32'(addr));
    end else begin
      check({tag, ".pc_o"},  32'(pc_o),  32'(addr));
      check({tag, ".opr_o"}, 32'(opr_o), 32'd0);
    end
    check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    if (we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
  endtask

  // Entered in F_A; leaves in the cycle after WB. Optionally pulses start during F_C.
  task automatic instr(input string tag, input logic [7:0] pc, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] wd, input bit pulse_fc);
    cyc({tag, ".FA"}, 1'b0, pc, 1'b0, 8'd0);
    cyc({tag, ".FB"}, 1'b0, pc + 8'd1, 1'b0, 8'd0);
    if (pulse_fc) start = 1'b1;
    cyc({tag, ".FC"}, 1'b0, pc + 8'd2, 1'b0, 8'd0);
    start = 1'b0;
    cyc({tag, ".RA"}, 1'b1, a, 1'b0, 8'd0);
    cyc({tag, ".RB"}, 1'b1, b, 1'b0, 8'd0);
    cyc({tag, ".WB"}, 1'b1, b, 1'b1, wd);
    $display("instr %s: pc=%0d A=%0d B=%0d wdata=%0h", tag, pc, a, b, wd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();
    check("idle.busy", 32'(busy), 32'd0);

    // Instruction 0: mem[7] = 5 - 2 = 3, not taken, next pc 3
    mem[0] = 8'd6; mem[1] = 8'd7; mem[2] = 8'd9;
    mem[3] = 8'd6; mem[4] = 8'd7; mem[5] = 8'd9;
    mem[9] = 8'd6; mem[10] = 8'd7; mem[11] = 8'd12;
    mem[12] = 8'd6; mem[13] = 8'd7; mem[14] = 8'd255;
    mem[6] = 8'd2; mem[7] = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    instr("nobr", 8'd0, 8'd6, 8'd7, 8'd3, 1'b0);

    // At pc 3: 5 - 5 = 0, taken to 9
    mem[6] = 8'd5; mem[7] = 8'd5;
    instr("br_zero", 8'd3, 8'd6, 8'd7, 8'd0, 1'b0);

    // At pc 9: 4 - 5 = -1, taken to 12
    mem[6] = 8'd5; mem[7] = 8'd4;
    instr("br_neg", 8'd9, 8'd6, 8'd7, 8'hFF, 1'b0);

    // At pc 12: C = 255 with equal operands halts
    mem[6] = 8'd8; mem[7] = 8'd8;
    instr("halt", 8'd12, 8'd6, 8'd7, 8'd0, 1'b0);
    check("halt.halted",   32'(halted),   32'd1);
    check("halt.busy",     32'(busy),     32'd0);
    check("halt.mem_we",   32'(mem_we),   32'd0);
    check("halt.addr_sel", 32'(addr_sel), 32'd0);
    check("halt.pc_o",     32'(pc_o),     32'd12);
    tick();
    check("halt.stays", 32'(halted), 32'd1);

    // Restart from HALT at 0; a start during F_C must not disturb it. Branches to 254.
    mem[2] = 8'd254;
    mem[6] = 8'd3; mem[7] = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.halted", 32'(halted), 32'd0);
    instr("restart_ign", 8'd0, 8'd6, 8'd7, 8'd0, 1'b1);

    // Wrap at pc 254: fetches 254, 255, 0; 0x80 - 0x01 = 0x7F, not taken, next pc 1
    mem[254] = 8'd20; mem[255] = 8'd21;
    mem[20] = 8'h01; mem[21] = 8'h80;
    instr("wrap", 8'd254, 8'd20, 8'd21, 8'h7F, 1'b0);
    check("wrap.next_pc", 32'(pc_o), 32'd1);

    // Run into R_A of the next instruction, then reset for 2 cycles (start held in the 2nd)
    mem[1] = 8'd30; mem[2] = 8'd31; mem[3] = 8'd32;
    cyc("rst_mid.FA", 1'b0, 8'd1, 1'b0, 8'd0);
    cyc("rst_mid.FB", 1'b0, 8'd2, 1'b0, 8'd0);
    cyc("rst_mid.FC", 1'b0, 8'd3, 1'b0, 8'd0);
    check("rst_mid.RA.opr_o", 32'(opr_o), 32'd30);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid1");
    start = 1'b1;
    tick();
    check_reset_outputs("rst_mid2");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start.busy", 32'(busy), 32'd0);
    $display("reset mid-instruction: busy=%0d pc_o=%0d", busy, pc_o);

    // Fresh start after reset fetches from 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst.busy", 32'(busy), 32'd1);
    check("post_rst.pc_o", 32'(pc_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/subleq_seq.md
# subleq_seq

Instruction sequencer for the Subleq core. Walks each instruction (A, B, C) through fetch, operand read, subtract, write-back and branch, one memory access per cycle. Drives the address-select MUX stage directly downstream (MUX `a` = `pc_o`, `b` = `opr_o`, `sel` = `addr_sel`), whose output addresses the single-port memory. Also drives the memory write strobe and data.

## Interface
- `P_DATA`, 8: word width. Addresses are words, so the address space is 2^P_DATA words.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins execution at address 0 from IDLE or HALT.
- `mem_rdata`  in  P_DATA  memory read data, valid the cycle after the address is presented (synchronous read).
- `addr_sel`  out  1  MUX select: 0 = `pc_o`, 1 = `opr_o`.
- `pc_o`  out  P_DATA  instruction-fetch address (PC + word offset).
- `opr_o`  out  P_DATA  operand address (A or B).
- `mem_we`  out  1  write strobe; address comes from the MUX.
- `mem_wdata`  out  P_DATA  write-back data, mem[B] − mem[A].
- `busy`  out  1  high in any state other than IDLE or HALT.
- `halted`  out  1  high in HALT.

## Operation
- Internal registers: `pc`, `ra`, `rb`, `rc`, `va`.
- States and per-state outputs:
  - IDLE: waits for `start`; `addr_sel`=0, `pc_o`=pc.
  - F_A: `addr_sel`=0, `pc_o`=pc.
  - F_B: `pc_o`=pc+1; captures `ra`<=rdata.
  - F_C: `pc_o`=pc+2; captures `rb`<=rdata.
  - R_A: `addr_sel`=1, `opr_o`=ra; captures `rc`<=rdata.
  - R_B: `addr_sel`=1, `opr_o`=rb; captures `va`<=rdata (mem[A]).
  - WB: `addr_sel`=1, `opr_o`=rb, `mem_we`=1, `mem_wdata`=rdata−va (rdata is mem[B]).
  - HALT.
- Sequence: IDLE --start--> F_A (pc<=0) → F_B → F_C → R_A → R_B → WB.
- Exit from WB, with d = rdata−va:
  - If d ≤ 0 (signed), branch is taken: pc<=rc.
  - If rc = all-ones and the branch is taken: go to HALT, pc unchanged, write still performed. Otherwise go to F_A.
  - If not taken: pc<=pc+3, go to F_A.
- Arithmetic: all P_DATA-bit modulo 2^P_DATA.
  - Subtraction wraps; the sign test uses the wrapped result's MSB, or zero.
  - pc+1, pc+2 and pc+3 wrap, e.g. pc=254 fetches 254, 255, 0.
- HALT --start--> F_A with pc<=0. `start` is ignored in all other states.
- A = B is legal: write 0, branch taken.

## Timing
- Reset values: state IDLE, pc/ra/rb/rc/va=0, `addr_sel`=0, `pc_o`=0, `opr_o`=0, `mem_we`=0, `mem_wdata`=0, `busy`=0, `halted`=0.
- Outputs are decoded from state and registers only, except `mem_wdata`, which is combinational from `mem_rdata` in WB.
- Latency:
  - Exactly 6 cycles per instruction (F_A..WB).
  - First fetch address appears the cycle after `start`.
  - `halted` asserts the cycle after the halting WB.
- `mem_we` is high for exactly one cycle per instruction, in WB. `opr_o` is 0 when `addr_sel`=0.
- `rst` mid-instruction: the next cycle is IDLE with reset values. No write is issued in that cycle, even if `rst` arrives in WB.
- `start` and `rst` together: `rst` wins.

## Test plan
- Reset: hold `rst` 2 cycles in mid-instruction (state R_A) → all outputs at reset values, state IDLE, `busy`=0.
- Single non-branching instruction: mem[0..2]={6,7,9}, mem[6]=2, mem[7]=5; pulse `start`.
  - Address sequence 0,1,2,6,7,7.
  - WB writes 3 to addr 7, `mem_we` high for exactly that cycle.
  - Next fetch at pc=3.
- Taken branch: mem[6]=5, mem[7]=5 → writes 0; next fetch at 9. Repeat with mem[7]=4 → writes 255 (−1), branch taken.
- Halt: instruction {6,7,255} with mem[6]=mem[7] → write 0, `halted`=1 and `busy`=0 the next cycle. A further `start` restarts at fetch address 0.
- Wrap: pc=254, non-branching → fetch addresses 254, 255, 0, next pc=1. Subtraction 0x80−0x01 = 0x7F → not taken.
- Ignored start: pulse `start` during F_C → sequence unchanged and completes in 6 cycles.
